// File: rtl/neuron_train_seq.sv
// Training sequencer for one neuron_learn: latches a sample, toggles the trigger, waits SETTLE, captures and scores it.
// Optional early stop (TRAIN_SEQ_EARLY_STOP_EN) freezes learning once an epoch error drops below stop_thresh.
module neuron_train_seq #(
  parameter int N         = 16,
  parameter int SETTLE    = 2,
  parameter int EPOCH_LEN = 8,
  parameter int SCRAMBLE  = 4,
  parameter int ZW        = 8,
  localparam int EW       = ZW + $clog2(EPOCH_LEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init_req,
  input  logic            learn_en,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [N*ZW-1:0] s_in,
  input  logic [ZW-1:0]   s_expected,
  output logic            nr_trigger,
  output logic            nr_valid,
  output logic            nr_learn,
  output logic [N*ZW-1:0] nr_in,
  output logic [ZW-1:0]   nr_expected_out,
  input  logic [ZW-1:0]   nr_out,
  output logic            r_valid,
  output logic [ZW-1:0]   r_out,
  output logic [ZW-1:0]   r_err,
  output logic            epoch_done,
  output logic [EW-1:0]   epoch_err,
  output logic [15:0]     epoch_cnt,
`ifdef TRAIN_SEQ_EARLY_STOP_EN
  input  logic [EW-1:0]   stop_thresh,
  output logic            converged,
`endif
  output logic            busy
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int KW = $clog2(SCRAMBLE + 1);
  localparam int CW = $clog2(EPOCH_LEN + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SCRAMBLE, ST_APPLY, ST_SETTLE, ST_CAPTURE, ST_REPORT
  } state_t;

  state_t            state_q, state_d;
  logic              trig_q, trig_d;
  logic              valid_q, valid_d;
  logic              learn_q, learn_d;
  logic [N*ZW-1:0]   in_q, in_d;
  logic [ZW-1:0]     exp_q, exp_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [KW-1:0]     scr_q, scr_d;
  logic [CW-1:0]     smp_q, smp_d;
  logic [EW-1:0]     acc_q, acc_d;
  logic              rv_q, rv_d;
  logic [ZW-1:0]     rout_q, rout_d;
  logic [ZW-1:0]     rerr_q, rerr_d;
  logic              ed_q, ed_d;
  logic [EW-1:0]     eerr_q, eerr_d;
  logic [15:0]       ecnt_q, ecnt_d;
  logic              conv_q, conv_d;
  logic [ZW-1:0]     err_c;

  assign err_c = (exp_q >= nr_out) ? (exp_q - nr_out) : (nr_out - exp_q);

  always_comb begin
    state_d  = state_q;
    trig_d   = trig_q;
    valid_d  = valid_q;
    learn_d  = learn_q;
    in_d     = in_q;
    exp_d    = exp_q;
    settle_d = settle_q;
    scr_d    = scr_q;
    smp_d    = smp_q;
    acc_d    = acc_q;
    rv_d     = 1'b0;
    rout_d   = rout_q;
    rerr_d   = rerr_q;
    ed_d     = 1'b0;
    eerr_d   = eerr_q;
    ecnt_d   = ecnt_q;
    conv_d   = conv_q;
    case (state_q)
      ST_IDLE: begin
        if (init_req) begin
          state_d = ST_SCRAMBLE;
          valid_d = 1'b0;
          scr_d   = KW'(SCRAMBLE - 1);
          conv_d  = 1'b0;
        end else if (s_valid) begin
          state_d = ST_APPLY;
          in_d    = s_in;
          exp_d   = s_expected;
          valid_d = 1'b1;
`ifdef TRAIN_SEQ_EARLY_STOP_EN
          learn_d = learn_en & ~conv_q;
`else
          learn_d = learn_en;
`endif
        end
      end
      ST_SCRAMBLE: begin
        trig_d = ~trig_q;
        if (scr_q == '0) state_d = ST_IDLE;
        else             scr_d   = scr_q - KW'(1);
      end
      ST_APPLY: begin
        trig_d   = ~trig_q;
        settle_d = SW'(SETTLE - 1);
        state_d  = (SETTLE == 1) ? ST_CAPTURE : ST_SETTLE;
      end
      ST_SETTLE: begin
        // The APPLY cycle is the first settle cycle, so leave one count early.
        settle_d = settle_q - SW'(1);
        if (settle_q <= SW'(1)) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        rout_d  = nr_out;
        rerr_d  = err_c;
        rv_d    = 1'b1;
        acc_d   = acc_q + EW'(err_c);
        smp_d   = smp_q + CW'(1);
        state_d = (smp_q == CW'(EPOCH_LEN - 1)) ? ST_REPORT : ST_IDLE;
      end
      ST_REPORT: begin
        eerr_d  = acc_q;
        ed_d    = 1'b1;
        ecnt_d  = ecnt_q + 16'd1;
        acc_d   = '0;
        smp_d   = '0;
`ifdef TRAIN_SEQ_EARLY_STOP_EN
        if (acc_q < stop_thresh) conv_d = 1'b1;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      trig_q   <= 1'b0;
      valid_q  <= 1'b0;
      learn_q  <= 1'b0;
      in_q     <= '0;
      exp_q    <= '0;
      settle_q <= '0;
      scr_q    <= '0;
      smp_q    <= '0;
      acc_q    <= '0;
      rv_q     <= 1'b0;
      rout_q   <= '0;
      rerr_q   <= '0;
      ed_q     <= 1'b0;
      eerr_q   <= '0;
      ecnt_q   <= '0;
      conv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      trig_q   <= trig_d;
      valid_q  <= valid_d;
      learn_q  <= learn_d;
      in_q     <= in_d;
      exp_q    <= exp_d;
      settle_q <= settle_d;
      scr_q    <= scr_d;
      smp_q    <= smp_d;
      acc_q    <= acc_d;
      rv_q     <= rv_d;
      rout_q   <= rout_d;
      rerr_q   <= rerr_d;
      ed_q     <= ed_d;
      eerr_q   <= eerr_d;
      ecnt_q   <= ecnt_d;
      conv_q   <= conv_d;
    end
  end

  assign s_ready         = (state_q == ST_IDLE) && !init_req;
  assign busy            = (state_q != ST_IDLE);
  assign nr_trigger      = trig_q;
  assign nr_valid        = valid_q;
  assign nr_learn        = learn_q;
  assign nr_in           = in_q;
  assign nr_expected_out = exp_q;
  assign r_valid         = rv_q;
  assign r_out           = rout_q;
  assign r_err           = rerr_q;
  assign epoch_done      = ed_q;
  assign epoch_err       = eerr_q;
  assign epoch_cnt       = ecnt_q;
`ifdef TRAIN_SEQ_EARLY_STOP_EN
  assign converged       = conv_q;
`else
  logic unused_conv;
  assign unused_conv     = conv_q;
`endif

endmodule

// File: tb/tb_neuron_train_seq.sv
// Bench for neuron_train_seq: randomized samples against an arithmetic per-sample / per-epoch error model.
module tb_neuron_train_seq;
  localparam int N = 16, SETTLE = 2, EPOCH_LEN = 8, SCRAMBLE = 4, ZW = 8;
  localparam int EW = ZW + $clog2(EPOCH_LEN + 1);
  localparam int L  = SETTLE + 2;

  logic            clk = 1'b0;
  logic            rst, init_req, learn_en, s_valid, s_ready;
  logic [N*ZW-1:0] s_in, nr_in;
  logic [ZW-1:0]   s_expected, nr_expected_out, nr_out, r_out, r_err;
  logic            nr_trigger, nr_valid, nr_learn, r_valid, epoch_done, busy;
  logic [EW-1:0]   epoch_err;
  logic [15:0]     epoch_cnt;
`ifdef TRAIN_SEQ_EARLY_STOP_EN
  logic [EW-1:0]   stop_thresh;
  logic            converged;
`endif

  int        n_cmp = 0;
  int        n_bad = 0;
  int        m_acc = 0;
  int        m_smp = 0;
  logic [15:0] m_ecnt = '0;
  bit        m_conv = 0;
  int        m_thresh = 0;

  always #5 clk = ~clk;

  neuron_train_seq #(.N(N), .SETTLE(SETTLE), .EPOCH_LEN(EPOCH_LEN), .SCRAMBLE(SCRAMBLE), .ZW(ZW)) dut (
    .clk(clk), .rst(rst), .init_req(init_req), .learn_en(learn_en),
    .s_valid(s_valid), .s_ready(s_ready), .s_in(s_in), .s_expected(s_expected),
    .nr_trigger(nr_trigger), .nr_valid(nr_valid), .nr_learn(nr_learn),
    .nr_in(nr_in), .nr_expected_out(nr_expected_out), .nr_out(nr_out),
    .r_valid(r_valid), .r_out(r_out), .r_err(r_err),
    .epoch_done(epoch_done), .epoch_err(epoch_err), .epoch_cnt(epoch_cnt),
`ifdef TRAIN_SEQ_EARLY_STOP_EN
    .stop_thresh(stop_thresh), .converged(converged),
`endif
    .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full sample transaction; starts and ends 1ns after a rising edge.
  task automatic do_sample(input logic [ZW-1:0] ex, input logic [ZW-1:0] ou,
                           input logic le, input bit hold, input bit poke_init);
    logic [N*ZW-1:0] din;
    logic            tprev;
    int              tog, err;
    bit              exp_learn;
    for (int i = 0; i < N; i++) din[i*ZW +: ZW] = ZW'($urandom);
    s_in = din; s_expected = ex; learn_en = le; nr_out = ou; s_valid = 1'b1;
    for (int w = 0; w < 20 && !s_ready; w++) step();
    check("accept_ready", s_ready, 1);
    tprev = nr_trigger; tog = 0;
    exp_learn = le && !m_conv;
    err = int'(ex) - int'(ou);
    if (err < 0) err = -err;
    step();
    if (!hold) s_valid = 1'b0;
    s_in = ~din; s_expected = ~ex; learn_en = ~le;
    for (int k = 1; k <= L; k++) begin
      check("r_valid_timing", r_valid, (k == L));
      check("nr_in_stable", nr_in, din);
      check("nr_exp_stable", nr_expected_out, ex);
      check("nr_valid_held", nr_valid, 1);
      check("nr_learn", nr_learn, exp_learn);
      if (k < L) check("s_ready_low", s_ready, 0);
      if (nr_trigger !== tprev) tog++;
      tprev = nr_trigger;
      if (k < L) begin
        init_req = poke_init && (k <= 2);
        step();
      end
    end
    check("r_err", r_err, err);
    check("r_out", r_out, ou);
    check("trigger_toggles", tog, 1);
    m_acc += err; m_smp++;
    if (m_smp == EPOCH_LEN) begin
      check("epoch_done_early", epoch_done, 0);
      step();
      m_ecnt++;
      check("epoch_done", epoch_done, 1);
      check("epoch_err", epoch_err, m_acc);
      check("epoch_cnt", epoch_cnt, m_ecnt);
      check("r_valid_pulse", r_valid, 0);
      if (m_acc < m_thresh) m_conv = 1;
      m_acc = 0; m_smp = 0;
    end else begin
      check("epoch_done_idle", epoch_done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ZW-1:0] ex, ou;
    logic          tprev;
    int            tog;
    rst = 1; init_req = 0; learn_en = 0; s_valid = 0; s_in = '0; s_expected = '0; nr_out = '0;
`ifdef TRAIN_SEQ_EARLY_STOP_EN
    stop_thresh = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_trigger", nr_trigger, 0);
    check("rst_nr_valid", nr_valid, 0);
    check("rst_nr_learn", nr_learn, 0);
    check("rst_nr_in", nr_in, 0);
    check("rst_nr_exp", nr_expected_out, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_out", r_out, 0);
    check("rst_r_err", r_err, 0);
    check("rst_epoch_done", epoch_done, 0);
    check("rst_epoch_err", epoch_err, 0);
    check("rst_epoch_cnt", epoch_cnt, 0);
    rst = 0;
    step();
    check("idle_s_ready", s_ready, 1);
    check("idle_busy", busy, 0);

    do_sample(8'h60, 8'h40, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of SETTLE discards the transaction.
    s_in = {N{8'h5A}}; s_expected = 8'h33; s_valid = 1; learn_en = 1;
    step();
    s_valid = 0;
    step();
    check("mid_busy", busy, 1);
    rst = 1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", s_ready, 1);
    check("mid_rst_nr_valid", nr_valid, 0);
    check("mid_rst_epoch_cnt", epoch_cnt, 0);
    step();
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      check("mid_rst_no_rvalid", r_valid, 0);
      check("mid_rst_no_edone", epoch_done, 0);
      step();
    end
    m_acc = 0; m_smp = 0; m_ecnt = '0;

    // Full epoch, error 0x10 per sample, s_valid held high throughout.
    for (int i = 0; i < EPOCH_LEN; i++) begin
      ex = ZW'($urandom_range(16, 255));
      ou = (($urandom & 1) == 1 && ex <= 8'd239) ? ex + 8'd16 : ex - 8'd16;
      do_sample(ex, ou, 1'($urandom), 1'b1, 1'b0);
    end
    s_valid = 0;
    check("epoch_err_0x80", epoch_err, 'h80);
    check("epoch_cnt_1", epoch_cnt, 1);

    // Random epoch; a few samples see init_req while busy.
    for (int i = 0; i < EPOCH_LEN; i++)
      do_sample(ZW'($urandom), ZW'($urandom), 1'($urandom), 1'b0, (i == 2 || i == 5));
    check("epoch_cnt_2", epoch_cnt, 2);

    // Init scramble from IDLE.
    init_req = 1; tprev = nr_trigger; tog = 0;
    step();
    init_req = 0;
    for (int k = 1; k <= SCRAMBLE + 2; k++) begin
      check("scr_nr_valid", nr_valid, 0);
      check("scr_busy", busy, (k <= SCRAMBLE));
      if (nr_trigger !== tprev) tog++;
      tprev = nr_trigger;
      step();
    end
    check("scr_toggles", tog, SCRAMBLE);
    check("scr_epoch_cnt_kept", epoch_cnt, 2);
    m_conv = 0;

`ifdef TRAIN_SEQ_EARLY_STOP_EN
    stop_thresh = 'h81; m_thresh = 'h81;
    for (int i = 0; i < EPOCH_LEN; i++) begin
      ex = ZW'($urandom_range(16, 255));
      do_sample(ex, ex - 8'd16, 1'b1, 1'b0, 1'b0);
    end
    check("es_converged", converged, 1);
    do_sample(ZW'($urandom), ZW'($urandom), 1'b1, 1'b0, 1'b0);
    init_req = 1;
    step();
    init_req = 0;
    check("es_init_clears", converged, 0);
    m_conv = 0;
    for (int w = 0; w < 20 && busy; w++) step();
    check("es_idle", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
